// File: rtl/instruction_fetch_stage.sv
// MIPS instruction fetch stage: owns the fetch PC, issues one-at-a-time word requests
// to instruction memory, buffers a word under stall and applies delay-slot branch redirects.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_enable,
  input  logic [31:0] branch_target,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] if_program_counter,
  output logic [31:0] if_instruction,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    FULL    = 2'd2
  } fetch_state_t;

  fetch_state_t state, state_next;

  logic [31:0] req_addr, req_addr_next;
  logic [31:0] redirect_pc, redirect_pc_next;
  logic [31:0] skid_pc, skid_pc_next;
  logic [31:0] skid_inst, skid_inst_next;
  logic [31:0] if_program_counter_next;
  logic [31:0] if_instruction_next;
  logic        if_valid_next;

  logic        take_branch;
  logic [31:0] discard_target;

  // Branches are only honoured on edges where the IF/ID buffer actually samples.
  assign take_branch    = !stall && branch_enable;
  assign discard_target = take_branch ? branch_target : redirect_pc;

  // Request depends only on registered state and reset, never on stall or branch inputs.
  assign imem_request = (state != FULL) && !reset;
  assign imem_address = req_addr;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_next              = state;
    req_addr_next           = req_addr;
    redirect_pc_next        = redirect_pc;
    skid_pc_next            = skid_pc;
    skid_inst_next          = skid_inst;
    if_program_counter_next = if_program_counter;
    if_instruction_next     = if_instruction;
    if_valid_next           = if_valid;

    // An unstalled edge consumes the slot; it is refilled below only if a word is available.
    if (!stall) begin
      if_valid_next       = 1'b0;
      if_instruction_next = 32'h0000_0000;
    end

    unique case (state)
      FETCH: begin
        if (take_branch) begin
          if (imem_ready) begin
            req_addr_next = branch_target;
          end else begin
            redirect_pc_next = branch_target;
            state_next       = DISCARD;
          end
        end else if (imem_ready) begin
          if (!stall || !if_valid) begin
            if_program_counter_next = req_addr;
            if_instruction_next     = imem_data;
            if_valid_next           = 1'b1;
          end else begin
            skid_pc_next   = req_addr;
            skid_inst_next = imem_data;
            state_next     = FULL;
          end
          req_addr_next = req_addr + 32'd4;
        end
      end

      DISCARD: begin
        if (take_branch) begin
          redirect_pc_next = branch_target;
        end
        if (imem_ready) begin
          req_addr_next = discard_target;
          state_next    = FETCH;
        end
      end

      FULL: begin
        if (!stall) begin
          if (branch_enable) begin
            req_addr_next = branch_target;
          end else begin
            if_program_counter_next = skid_pc;
            if_instruction_next     = skid_inst;
            if_valid_next           = 1'b1;
          end
          state_next = FETCH;
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= FETCH;
      req_addr           <= RESET_PC;
      redirect_pc        <= 32'h0000_0000;
      skid_pc            <= 32'h0000_0000;
      skid_inst          <= 32'h0000_0000;
      if_program_counter <= 32'h0000_0000;
      if_instruction     <= 32'h0000_0000;
      if_valid           <= 1'b0;
    end else begin
      state              <= state_next;
      req_addr           <= req_addr_next;
      redirect_pc        <= redirect_pc_next;
      skid_pc            <= skid_pc_next;
      skid_inst          <= skid_inst_next;
      if_program_counter <= if_program_counter_next;
      if_instruction     <= if_instruction_next;
      if_valid           <= if_valid_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: memory returns address XOR a key as data,
// and every expected value below is hand-derived from the fetch-stage behaviour.
module tb_instruction_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_enable;
  logic [31:0] branch_target;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] if_program_counter;
  logic [31:0] if_instruction;
  logic        if_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  instruction_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .branch_enable      (branch_enable),
    .branch_target      (branch_target),
    .imem_request       (imem_request),
    .imem_address       (imem_address),
    .imem_ready         (imem_ready),
    .imem_data          (imem_data),
    .if_program_counter (if_program_counter),
    .if_instruction     (if_instruction),
    .if_valid           (if_valid)
  );

  always #5 clock = ~clock;

  assign imem_data = imem_address ^ DATA_KEY;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_slot(input string tag, input logic [31:0] pc, input logic valid);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
    check({tag, ".pc"}, if_program_counter, pc);
    check({tag, ".inst"}, if_instruction, valid ? (pc ^ DATA_KEY) : 32'h0000_0000);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_enable = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst.req", {31'd0, imem_request}, 32'd0);
    check("rst.addr", imem_address, RESET_PC);
    check_slot("rst", 32'h0000_0000, 1'b0);

    // Zero-wait streaming from RESET_PC
    reset = 1'b0; #1;
    check("first.req", {31'd0, imem_request}, 32'd1);
    check("first.addr", imem_address, RESET_PC);
    tick(); check_slot("s0", 32'h0040_0000, 1'b1);
    tick(); check_slot("s1", 32'h0040_0004, 1'b1);
    tick(); check_slot("s2", 32'h0040_0008, 1'b1);

    // Ready every third cycle: two bubbles, request held stable
    imem_ready = 1'b0;
    tick(); check_slot("wait0", 32'h0040_0008, 1'b0);
    check("wait0.req", {31'd0, imem_request}, 32'd1);
    check("wait0.addr", imem_address, 32'h0040_000C);
    tick(); check_slot("wait1", 32'h0040_0008, 1'b0);
    check("wait1.addr", imem_address, 32'h0040_000C);
    imem_ready = 1'b1;
    tick(); check_slot("wait2", 32'h0040_000C, 1'b1);

    // Stall for three cycles: one word skids, request drops, slot held
    stall = 1'b1;
    tick(); check_slot("stall0", 32'h0040_000C, 1'b1);
    check("stall0.req", {31'd0, imem_request}, 32'd0);
    tick(); check_slot("stall1", 32'h0040_000C, 1'b1);
    check("stall1.addr", imem_address, 32'h0040_0014);
    tick(); check_slot("stall2", 32'h0040_000C, 1'b1);
    check("stall2.req", {31'd0, imem_request}, 32'd0);
    stall = 1'b0;
    tick(); check_slot("release", 32'h0040_0010, 1'b1);
    check("release.req", {31'd0, imem_request}, 32'd1);
    check("release.addr", imem_address, 32'h0040_0014);

    // Branch with slot holding the delay slot and memory ready
    branch_enable = 1'b1; branch_target = 32'h0040_1000;
    tick(); check_slot("br", 32'h0040_0010, 1'b0);
    check("br.addr", imem_address, 32'h0040_1000);
    branch_enable = 1'b0;
    tick(); check_slot("br.tgt", 32'h0040_1000, 1'b1);

    // Branch while a request is outstanding: stale word dropped via DISCARD
    imem_ready = 1'b0;
    tick(); check_slot("out0", 32'h0040_1000, 1'b0);
    branch_enable = 1'b1; branch_target = 32'h0050_0000;
    tick(); check_slot("out.br", 32'h0040_1000, 1'b0);
    check("out.br.req", {31'd0, imem_request}, 32'd1);
    check("out.br.addr", imem_address, 32'h0040_1004);
    branch_enable = 1'b0;
    tick(); check("disc.addr", imem_address, 32'h0040_1004);
    imem_ready = 1'b1;
    tick(); check_slot("disc.drop", 32'h0040_1000, 1'b0);
    check("disc.redir", imem_address, 32'h0050_0000);
    tick(); check_slot("disc.tgt", 32'h0050_0000, 1'b1);

    // Address wrap at the top of the address space
    branch_enable = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick(); check("wrap.br", imem_address, 32'hFFFF_FFFC);
    branch_enable = 1'b0;
    tick(); check_slot("wrap.slot", 32'hFFFF_FFFC, 1'b1);
    check("wrap.addr", imem_address, 32'h0000_0000);

    // Reset asserted while a request is waiting
    imem_ready = 1'b0;
    tick(); check("midrst.wait", imem_address, 32'h0000_0000);
    reset = 1'b1; #1;
    check("midrst.req", {31'd0, imem_request}, 32'd0);
    tick(); check("midrst.req2", {31'd0, imem_request}, 32'd0);
    check_slot("midrst", 32'h0000_0000, 1'b0);
    reset = 1'b0; imem_ready = 1'b1; #1;
    check("postrst.req", {31'd0, imem_request}, 32'd1);
    check("postrst.addr", imem_address, RESET_PC);
    tick(); check_slot("postrst", 32'h0040_0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
